wptr_full_gray: RTL and testbench
=================================

WPTR_FULL_GRAY -- requirements
Module: wptr_full_gray

Interface
REQ-001 Parameter: ASIZE, 4, address width; FIFO depth 2^ASIZE; ASIZE >= 2 SHALL hold.
REQ-002 Parameter: AF_THRESH, 2^ASIZE-2, almost-full level; used only when WPTR_ALMOST_FULL_EN is defined.
REQ-003 clk  input  1  write-domain clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 winc  input  1  write request.
REQ-006 rptr_gray  input  ASIZE+1  read pointer, Gray-coded, from the asynchronous read domain.
REQ-007 waddr  output  ASIZE  write address into storage RAM.
REQ-008 wptr_gray  output  ASIZE+1  registered Gray write pointer, sent to the read domain.
REQ-009 wfull  output  1  registered full flag.
REQ-010 wlevel  output  ASIZE+1  registered fill level; present only with WPTR_ALMOST_FULL_EN.
REQ-011 walmost_full  output  1  registered almost-full flag; present only with WPTR_ALMOST_FULL_EN.

Function
REQ-012 rptr_gray SHALL pass through a 2-flop synchronizer (rq1, rq2) with no logic between stages; only rq2 is used downstream.
REQ-013 push = winc & ~wfull; a winc while wfull is high SHALL be ignored with no state change.
REQ-014 Internal binary pointer wbin (ASIZE+1 bits): wbin_next = wbin + push, wrapping modulo 2^(ASIZE+1).
REQ-015 wgray_next = (wbin_next >> 1) ^ wbin_next; wbin and wptr_gray SHALL load wbin_next and wgray_next on every edge.
REQ-016 waddr = wbin[ASIZE-1:0]; combinational from the register, no extra latency.
REQ-017 wfull SHALL register (wgray_next == {~rq2[ASIZE:ASIZE-1], rq2[ASIZE-2:0]}).
REQ-018 wfull SHALL assert on the same edge as the push that fills the last entry; no overshoot is permitted.
REQ-019 wfull SHALL deassert on the 3rd rising edge after a rptr_gray change that meets setup (2 sync edges + 1 flag register edge); pessimistic lag is the required behaviour.
REQ-020 wptr_gray SHALL change by at most one bit per clock.

Reset
REQ-021 On rst_n low, asynchronously: rq1, rq2, wbin, wptr_gray = 0; wfull = 0; wlevel = 0; walmost_full = 0; waddr = 0.
REQ-022 Reset asserted mid-operation SHALL discard all pointer state; the first push after release SHALL write waddr 0.

Configuration
REQ-023 Macro WPTR_ALMOST_FULL_EN: when defined, rbin = Gray-to-binary of rq2, computed internally as a combinational prefix XOR from MSB down.
REQ-024 With the macro, wlevel SHALL register (wbin_next - rbin) mod 2^(ASIZE+1), and walmost_full SHALL register (that value >= AF_THRESH).
REQ-025 Without the macro, wlevel, walmost_full and the conversion logic SHALL be absent; all other behaviour is unchanged.

Verification (ASIZE=4)
REQ-026 Reset with rptr_gray=0, then winc=1 for 16 clocks -> wfull rises on the 16th edge, waddr=0, wptr_gray=5'b11000.
REQ-027 Keep winc=1 for 5 more clocks while full -> wptr_gray, waddr and wfull remain unchanged.
REQ-028 While full, set rptr_gray=5'b00001 -> wfull drops on the 3rd edge; the next push sets waddr=1 and wfull=1 again.
REQ-029 Apply 32 pushes with rptr_gray tracking wptr_gray (2-cycle delay) -> wptr_gray returns to 0 and wfull never asserts; every wptr_gray transition differs in exactly one bit.
REQ-030 Apply 7 pushes, then drop rst_n for one half-cycle -> all outputs are 0 immediately, without waiting for a clock edge.
REQ-031 With the macro defined, AF_THRESH=14, rptr_gray=0 -> walmost_full rises on the 14th push with wlevel=14 and stays high through full (wlevel=16).

Source files
------------

// File: rtl/wptr_full_gray.sv
// Write-domain pointer and full-flag logic for an asynchronous FIFO.
// Optional macro WPTR_ALMOST_FULL_EN adds wlevel and walmost_full outputs.
module wptr_full_gray #(
    parameter int ASIZE     = 4,
    parameter int AF_THRESH = (1 << ASIZE) - 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             winc,
    input  logic [ASIZE:0]   rptr_gray,
    output logic [ASIZE-1:0] waddr,
    output logic [ASIZE:0]   wptr_gray,
    output logic             wfull
`ifdef WPTR_ALMOST_FULL_EN
    ,
    output logic [ASIZE:0]   wlevel,
    output logic             walmost_full
`endif
);

    if (ASIZE < 2) begin : g_bad_asize
        $error("wptr_full_gray: ASIZE must be at least 2");
    end
    if (AF_THRESH < 0 || AF_THRESH > (1 << ASIZE)) begin : g_bad_thresh
        $error("wptr_full_gray: AF_THRESH out of range");
    end

    logic [ASIZE:0] rq1;
    logic [ASIZE:0] rq2;
    logic [ASIZE:0] wbin;
    logic [ASIZE:0] wbin_next;
    logic [ASIZE:0] wgray_next;
    logic [ASIZE:0] full_cmp;
    logic           push;
    logic           wfull_next;

    // Plain two-flop synchronizer; nothing may sit between the stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq1 <= '0;
            rq2 <= '0;
        end else begin
            rq1 <= rptr_gray;
            rq2 <= rq1;
        end
    end

    always_comb begin
        push       = winc & ~wfull;
        wbin_next  = wbin + (ASIZE+1)'(push);
        wgray_next = (wbin_next >> 1) ^ wbin_next;
        full_cmp   = {~rq2[ASIZE:ASIZE-1], rq2[ASIZE-2:0]};
        wfull_next = (wgray_next == full_cmp);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin      <= '0;
            wptr_gray <= '0;
            wfull     <= 1'b0;
        end else begin
            wbin      <= wbin_next;
            wptr_gray <= wgray_next;
            wfull     <= wfull_next;
        end
    end

    assign waddr = wbin[ASIZE-1:0];

`ifdef WPTR_ALMOST_FULL_EN
    logic [ASIZE:0] rbin;
    logic [ASIZE:0] level_next;
    logic           acc;

    // Gray to binary: running XOR from the MSB downwards.
    always_comb begin
        rbin = '0;
        acc  = 1'b0;
        for (int i = ASIZE; i >= 0; i--) begin
            acc     = acc ^ rq2[i];
            rbin[i] = acc;
        end
        level_next = wbin_next - rbin;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wlevel       <= '0;
            walmost_full <= 1'b0;
        end else begin
            wlevel       <= level_next;
            walmost_full <= (level_next >= (ASIZE+1)'(AF_THRESH));
        end
    end
`endif

endmodule

// File: tb/tb_wptr_full_gray.sv
// Directed self-checking bench for wptr_full_gray with ASIZE=4.
// Almost-full checks are compiled in when WPTR_ALMOST_FULL_EN is defined.
module tb_wptr_full_gray;

    localparam int A = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         winc;
    logic [A:0]   rptr_gray;
    logic [A-1:0] waddr;
    logic [A:0]   wptr_gray;
    logic         wfull;
`ifdef WPTR_ALMOST_FULL_EN
    logic [A:0]   wlevel;
    logic         walmost_full;
`endif

    int ncmp = 0;
    int nerr = 0;

    wptr_full_gray #(.ASIZE(A)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .winc      (winc),
        .rptr_gray (rptr_gray),
        .waddr     (waddr),
        .wptr_gray (wptr_gray),
        .wfull     (wfull)
`ifdef WPTR_ALMOST_FULL_EN
        ,
        .wlevel       (wlevel),
        .walmost_full (walmost_full)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [A:0] g(input int v);
        logic [A:0] b;
        b = v[A:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_waddr"}, 32'(waddr), 0);
        chk({tag, "_wptr"}, 32'(wptr_gray), 0);
        chk({tag, "_wfull"}, 32'(wfull), 0);
`ifdef WPTR_ALMOST_FULL_EN
        chk({tag, "_wlevel"}, 32'(wlevel), 0);
        chk({tag, "_wafull"}, 32'(walmost_full), 0);
`endif
    endtask

    logic [A:0] prev;

    initial begin
        // Reset state, asynchronous
        rst_n = 1'b0;
        winc = 1'b0;
        rptr_gray = '0;
        #3;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Fill 16 entries with the read side idle
        winc = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("fill%0d_wfull", k), 32'(wfull), (k == 16) ? 1 : 0);
            chk($sformatf("fill%0d_waddr", k), 32'(waddr), k % 16);
`ifdef WPTR_ALMOST_FULL_EN
            chk($sformatf("fill%0d_wlevel", k), 32'(wlevel), k);
            chk($sformatf("fill%0d_waf", k), 32'(walmost_full),
                (k >= 14) ? 1 : 0);
`endif
        end
        chk("full_wptr", 32'(wptr_gray), 32'h18);

        // Writes while full are ignored
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_wfull", 32'(wfull), 1);
            chk("hold_wptr", 32'(wptr_gray), 32'h18);
            chk("hold_waddr", 32'(waddr), 0);
`ifdef WPTR_ALMOST_FULL_EN
            chk("hold_wlevel", 32'(wlevel), 16);
            chk("hold_waf", 32'(walmost_full), 1);
`endif
        end

        // One read frees a slot; flag lags by three edges
        rptr_gray = 5'b00001;
        tick();
        chk("rd_e1_wfull", 32'(wfull), 1);
        tick();
        chk("rd_e2_wfull", 32'(wfull), 1);
        tick();
        chk("rd_e3_wfull", 32'(wfull), 0);
        chk("rd_e3_waddr", 32'(waddr), 0);
        tick();
        chk("refill_wfull", 32'(wfull), 1);
        chk("refill_waddr", 32'(waddr), 1);
        chk("refill_wptr", 32'(wptr_gray), 32'h19);

        // Fresh start, then a full pointer lap with a trailing reader
        rst_n = 1'b0;
        winc = 1'b0;
        rptr_gray = '0;
        #1;
        chk_zero("reset2");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        winc = 1'b1;
        prev = wptr_gray;
        for (int k = 1; k <= 39; k++) begin
            rptr_gray = (k >= 3) ? g(k - 3) : '0;
            tick();
            chk($sformatf("lap%0d_wptr", k), 32'(wptr_gray), 32'(g(k)));
            chk($sformatf("lap%0d_wfull", k), 32'(wfull), 0);
            chk($sformatf("lap%0d_onebit", k),
                32'($countones(prev ^ wptr_gray)), 1);
            prev = wptr_gray;
            if (k == 32)
                chk("lap_wrap_wptr", 32'(wptr_gray), 0);
        end
        chk("pre_rst_waddr", 32'(waddr), 7);

        // Mid-operation reset acts without a clock edge
        @(negedge clk);
        rst_n = 1'b0;
        rptr_gray = '0;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        chk("post_rst_waddr", 32'(waddr), 0);
        tick();
        chk("post_rst_push_waddr", 32'(waddr), 1);
        chk("post_rst_push_wptr", 32'(wptr_gray), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
